// File: rtl/chain_pkg.sv
// chain_pkg: shared constants, clog2 helper and config check for register-chain users
`ifndef CHAIN_PKG_SV
`define CHAIN_PKG_SV
`define CHAIN_CFG_CHECK(D, R) \
  if ((R) >= (D) || (D) < 4 || ((D) & ((D) - 1)) != 0) begin : g_bad_cfg \
    $error("chain config: need RTT < DEPTH and DEPTH a power of two >= 4"); \
  end
`endif

package chain_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_RTT = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/chain_sink_mem.sv
// chain_sink_mem: simple dual-port register array, sync write, async read, no reset
module chain_sink_mem import chain_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // storage write; left unreset so it maps onto distributed RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/chain_sink.sv
// chain_sink: skid FIFO absorbing in-flight chain words, registered STALL back upstream (optional CHAIN_SINK_WATERMARK_EN adds max_count)
module chain_sink import chain_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int RTT = DEF_RTT,
  parameter int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             overflow
`ifdef CHAIN_SINK_WATERMARK_EN
  ,
  output logic [AW:0]      max_count
`endif
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH = (AW+1)'(DEPTH - RTT);

  `CHAIN_CFG_CHECK(DEPTH, RTT)

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_next;
  logic push, pop, full;

  assign out_valid = count != '0;
  assign full = count == FULL_CNT;
  assign pop = out_valid && out_ready;
  assign push = in_valid && (!full || pop);

  // occupancy after this edge; drives both count and the stall threshold
  always_comb
    count_next = (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;

  // pointers, occupancy, stall and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      stall <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      stall <= count_next >= THRESH;
      overflow <= overflow | (in_valid && full && !pop);
    end
  end

`ifdef CHAIN_SINK_WATERMARK_EN
  // high-water mark of occupancy for sizing RTT/DEPTH on hardware
  always_ff @(posedge clk)
    max_count <= !rst_n ? '0 : (count_next > max_count) ? count_next : max_count;
`endif

  chain_sink_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(out_data)
  );
endmodule

// File: tb/tb_chain_sink.sv
// tb_chain_sink: directed self-checking bench for chain_sink (DEPTH 32, RTT 16)
module tb_chain_sink;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic [31:0] in_data = 0;
  logic out_ready = 0;
  logic stall, out_valid, overflow;
  logic [31:0] out_data;
  logic [5:0] count;
`ifdef CHAIN_SINK_WATERMARK_EN
  logic [5:0] max_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  chain_sink dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .stall(stall),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .overflow(overflow)
`ifdef CHAIN_SINK_WATERMARK_EN
    ,
    .max_count(max_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_count", count, 6'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1;
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1;
      in_data = i;
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", out_data, 32'(i));
      chk("stream_count", count, 6'd1);
      chk("stream_stall", stall, 1'b0);
    end
    in_valid = 0;
    step();
    chk("stream_drained", count, 6'd0);
    out_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1;
      in_data = 100 + i;
      q.push_back(100 + i);
      step();
      chk("fill_count", count, 6'(i));
      chk("fill_stall", stall, i >= 16);
    end
    chk("fill_head", out_data, 32'd101);
    for (int i = 17; i <= 32; i++) begin
      in_data = 100 + i;
      q.push_back(100 + i);
      step();
    end
    chk("full_count", count, 6'd32);
    chk("full_ovf", overflow, 1'b0);
    chk("full_stall", stall, 1'b1);
    in_data = 32'hDEAD;
    step();
    chk("drop_ovf", overflow, 1'b1);
    chk("drop_count", count, 6'd32);
    chk("drop_head", out_data, 32'd101);
    out_ready = 1;
    for (int k = 0; k < 40; k++) begin
      in_data = 300 + k;
      chk("wrap_data", out_data, q[0]);
      void'(q.pop_front());
      q.push_back(300 + k);
      step();
      chk("wrap_count", count, 6'd32);
    end
    chk("wrap_ovf_sticky", overflow, 1'b1);
    in_valid = 0;
    for (int k = 0; k < 12; k++) begin
      chk("drain_data", out_data, q[0]);
      void'(q.pop_front());
      step();
    end
    chk("pre_rst_count", count, 6'd20);
    rst_n = 0;
    out_ready = 0;
    step();
    chk("mid_rst_count", count, 6'd0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    rst_n = 1;
    in_valid = 1;
    in_data = 32'h55;
    step();
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_data", out_data, 32'h55);
    chk("post_rst_count", count, 6'd1);
    rst_n = 0;
    in_valid = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 23; i++) begin
      in_valid = 1;
      in_data = 500 + i;
      step();
    end
    in_valid = 0;
    chk("peak_count", count, 6'd23);
    chk("peak_stall", stall, 1'b1);
    out_ready = 1;
    for (int k = 1; k <= 23; k++) begin
      chk("peak_drain_data", out_data, 32'(500 + k - 1));
      step();
      chk("peak_drain_count", count, 6'(23 - k));
      chk("peak_drain_stall", stall, (23 - k) >= 16);
    end
    chk("peak_empty_valid", out_valid, 1'b0);
    chk("peak_ovf", overflow, 1'b0);
`ifdef CHAIN_SINK_WATERMARK_EN
    chk("wm_peak", max_count, 6'd23);
    rst_n = 0;
    step();
    chk("wm_rst", max_count, 6'd0);
    rst_n = 1;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
